// File: rtl/vliw_scoreboard.sv
// vliw_scoreboard: register scoreboard for an N-lane VLIW pipeline, between ID and EX.
// Keeps one remaining-latency down-counter per architectural register (r0 excluded)
// and decides whether the bundle presented by decode may issue this cycle.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   in_valid              decode presents a bundle
//   src1, src2, src_en    per-lane source indices and source-used flags (2 per lane)
//   dst, wr_en, lat       per-lane destination, write enable, producer latency
//   flush                 squash the bundle and clear every pending counter
//   stall, issue          combinational issue decision for the current bundle
//   waw_same              two lanes of the issued bundle write the same non-zero dst
//   busy                  bit r set while counter[r] != 0
//
// Optional build macro SCB_PERF_EN adds saturating 32-bit counters
//   stall_cycles (cycles with stall=1) and raw_stalls (stalls with a RAW block).
module vliw_scoreboard #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MAX_LAT  = 4,
  parameter int unsigned LAT_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [LANES*REG_AW-1:0]   src1,
  input  logic [LANES*REG_AW-1:0]   src2,
  input  logic [2*LANES-1:0]        src_en,
  input  logic [LANES*REG_AW-1:0]   dst,
  input  logic [LANES-1:0]          wr_en,
  input  logic [LANES*LAT_W-1:0]    lat,
  input  logic                      flush,
  output logic                      stall,
  output logic                      issue,
  output logic                      waw_same,
  output logic [NUM_REGS-1:0]       busy
`ifdef SCB_PERF_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               raw_stalls
`endif
);

  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

  logic [LAT_W-1:0]  cnt     [NUM_REGS];
  logic [LAT_W-1:0]  cnt_nxt [NUM_REGS];
  logic [LAT_W-1:0]  eff_lat [LANES];
  logic [REG_AW-1:0] s1_idx  [LANES];
  logic [REG_AW-1:0] s2_idx  [LANES];
  logic [REG_AW-1:0] d_idx   [LANES];
  logic              raw_hit;
  logic              waw_hit;
  logic              same_dst;
  logic              go;

  // Per-lane field extraction; latencies above MAX_LAT are clamped
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      s1_idx[k]  = src1[k*REG_AW +: REG_AW];
      s2_idx[k]  = src2[k*REG_AW +: REG_AW];
      d_idx[k]   = dst[k*REG_AW +: REG_AW];
      eff_lat[k] = lat[k*LAT_W +: LAT_W];
      if (eff_lat[k] > LAT_MAX) eff_lat[k] = LAT_MAX;
    end
  end

  // Hazards are judged against the counters as registered at cycle start,
  // so a lane reading another lane's dst in the same bundle sees old state.
  always_comb begin
    raw_hit  = 1'b0;
    waw_hit  = 1'b0;
    same_dst = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (src_en[2*k] && (s1_idx[k] != '0) && (cnt[s1_idx[k]] != '0))
        raw_hit = 1'b1;
      if (src_en[2*k+1] && (s2_idx[k] != '0) && (cnt[s2_idx[k]] != '0))
        raw_hit = 1'b1;
      if (wr_en[k] && (d_idx[k] != '0) && (cnt[d_idx[k]] > eff_lat[k]))
        waw_hit = 1'b1;
      for (int j = k + 1; j < LANES; j++) begin
        if (wr_en[k] && wr_en[j] && (d_idx[k] == d_idx[j]) && (d_idx[k] != '0))
          same_dst = 1'b1;
      end
    end
  end

  // Issue decision; reset forces every decision output low
  assign go       = reset & in_valid & ~flush;
  assign stall    = go & (raw_hit | waw_hit);
  assign issue    = go & ~(raw_hit | waw_hit);
  assign waw_same = issue & same_dst;

  // Next counters: flush > set-by-issue (last lane wins) > decrement
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - LAT_W'(1) : '0;
    end
    if (issue) begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_en[k] && (d_idx[k] != '0) && (eff_lat[k] != '0))
          cnt_nxt[d_idx[k]] = eff_lat[k];
      end
    end
    if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_nxt[r] = '0;
    end
  end

  // Counter state; entry 0 never leaves zero since nothing writes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
    end
  end

  // Busy view of the counters
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy[r] = (r != 0) && (cnt[r] != '0);
    end
  end

`ifdef SCB_PERF_EN
  // Saturating stall statistics, untouched by flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      raw_stalls   <= '0;
    end else begin
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (stall && raw_hit && (raw_stalls != '1)) raw_stalls <= raw_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: doc/vliw_scoreboard.md
Name: vliw_scoreboard

Overview:
- Parametrised register scoreboard for the N-lane VLIW pipeline; successor to the fixed two-slot hazard/stall logic.
- Sits between decode (ID) and execute.
- Tracks the remaining-latency countdown of every in-flight register write.
- Stalls a bundle whose sources are not yet forwardable, or whose write would retire out of order (WAW).
- Supports per-instruction latency classes: ALU, load, compressed, multi-cycle.

Parameters:
LANES, 2, issue slots per bundle
NUM_REGS, 32, architectural registers; r0 is hardwired zero
REG_AW, 5, register index width (clog2 NUM_REGS)
MAX_LAT, 4, largest producer latency in cycles
LAT_W, 3, latency field width (clog2(MAX_LAT+1))

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  decode presents a bundle
src1  in  LANES*REG_AW  first source index per lane (lane k at [k*REG_AW +: REG_AW])
src2  in  LANES*REG_AW  second source index per lane
src_en  in  2*LANES  source-used flags (bit 2k = src1, bit 2k+1 = src2 of lane k)
dst  in  LANES*REG_AW  destination index per lane
wr_en  in  LANES  lane writes dst
lat  in  LANES*LAT_W  producer latency per lane
flush  in  1  squash current bundle; clear all pending counters
stall  out  1  bundle cannot issue this cycle
issue  out  1  bundle accepted this cycle
waw_same  out  1  two lanes of the accepted bundle write the same non-zero dst
busy  out  NUM_REGS  bit r = counter[r] != 0

Behaviour:
- State: one LAT_W-bit down-counter per register, r1..NUM_REGS-1. r0 has no counter; its busy bit is always 0.
- Reset (reset=0, asynchronous):
  - all counters 0;
  - stall=0, issue=0, waw_same=0, busy=0.
- All stall/issue decisions use counter values registered at the start of the cycle, i.e. before this cycle's decrement or set.
- RAW: lane k source s is blocked if src_en bit set AND index != 0 AND counter[index] != 0.
- Intra-bundle sources: lanes read pre-bundle state. A lane sourcing another lane's dst in the same bundle is never a hazard and never stalls.
- WAW in-flight: lane k is blocked if wr_en[k] AND dst != 0 AND counter[dst] > effective lat[k]. This keeps write order.
- Effective latency:
  - lat=0 means result available next cycle; no counter is set;
  - lat > MAX_LAT is clamped to MAX_LAT.
- stall = in_valid AND NOT flush AND (any lane blocked). Combinational from inputs and state.
- issue = in_valid AND NOT stall AND NOT flush. Combinational.
- On the clock edge, in priority order:
  1. flush=1: every counter is cleared to 0.
  2. Else, for each register, set-by-issue wins over decrement. If issue AND a lane writes r with effective lat>0, counter[r] <= effective lat.
  3. Otherwise a non-zero counter decrements by 1. Counters never wrap below 0.
- Same-dst lanes in one issued bundle: the highest-numbered lane wins (VLIW last-slot-wins). waw_same=1 combinationally in that cycle.
- A stalled bundle must be held stable by decode. The scoreboard keeps no bundle copy. Re-evaluation each cycle is stateless apart from the counters.
- Latency: a consumer of a lat=L producer issued in cycle t can issue at earliest cycle t+L+1; with lat=0, at t+1.
- Reset asserted mid-operation: counters clear immediately; outputs go to reset values within the same cycle.
- Widths: all index compares are REG_AW bits; latency compares are unsigned LAT_W bits.

Optional Feature:
SCB_PERF_EN
- Defined: adds output stall_cycles (32 bits) and output raw_stalls (32 bits), both cleared by reset.
  - stall_cycles increments on every cycle with stall=1.
  - raw_stalls increments only when stall=1 and at least one RAW block exists.
  - Both saturate at 0xFFFFFFFF and are unaffected by flush.
- Not defined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
1. Reset release. Bundle: lane0 wr r3 lat=2; lane1 wr r4 lat=0 -> issue=1. Next cycle: busy[3]=1, busy[4]=0; counter r3 = 2 then 1 then 0 over successive cycles.
2. lane0 wr r5 lat=3 issued cycle t; cycle t+1 lane1 src1=r5 -> stall=1 in t+1..t+3; issue=1 at t+4.
3. Same-bundle dependency: lane0 wr r6 lat=2, lane1 src1=r6 -> issue=1, no stall. Lane1 reads the old r6.
4. WAW: r7 pending with counter=3; new bundle lane0 wr r7 lat=1 -> stall until counter<=1, then issue; after issue counter[r7]=1.
5. Two lanes in one bundle write r8 with lat 1 and 3 -> waw_same=1, issue=1, counter[r8]=3 (lane1). Separately, a src of r0 while r0 is written -> never stalls, busy[0]=0.
6. Flush with r2=4 and r9=2 pending, in_valid=1 -> issue=0, stall=0; next cycle busy=0. Async reset pulse mid-countdown -> busy=0 immediately. With SCB_PERF_EN: three stall cycles -> stall_cycles=3, raw_stalls=3.
